ace_req_arbiter: RTL and testbench



---
 rtl/ace_req_arbiter_pkg.sv | 24 ++
 rtl/ace_req_arbiter_rr_picker.sv | 32 +++
 rtl/ace_req_arbiter.sv | 115 +++++++++++
 tb/tb_ace_req_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_req_arbiter_pkg.sv
// Shared types for the ACE request arbiter: controller op encoding and FSM states.
package ace_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_INVALID = 2'b01,
        OP_WRITE   = 2'b10,
        OP_RSVD    = 2'b11
    } ace_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT,
        DONE,
        ERROR
    } arb_state_e;

    function automatic logic op_is_write(input logic [1:0] op);
        return op == OP_WRITE;
    endfunction

endpackage

// File: rtl/ace_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);

    always_comb begin
        logic          found;
        int            idx;
        logic [IW-1:0] sel;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                id       = sel;
            end
        end
    end

endmodule

// File: rtl/ace_req_arbiter.sv
// Arbitrates NUM_REQ cache-side requesters onto the single ACE coherence controller,
// one transaction at a time, with snoop hold-off and a sticky WAIT timeout trap.
module ace_req_arbiter
    import ace_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int WRITE_PRIORITY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [2*NUM_REQ-1:0]       req_op,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       read_req,
    output logic                       invalid_req,
    output logic                       write_req,
    input  logic                       ace_ready,
    input  logic                       snoop_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_e         state;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      to_cnt;
    logic [NUM_REQ-1:0] wr_mask;
    logic [NUM_REQ-1:0] cand_mask;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_id;
    logic               accept;
    ace_op_e            win_op;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wr
        assign wr_mask[g] = req_valid[g] & op_is_write(req_op[2*g +: 2]);
    end

    assign cand_mask = (WRITE_PRIORITY != 0 && |wr_mask) ? wr_mask : req_valid;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (cand_mask),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    // rst_n gates the accept so req_ready is quiet while reset is held.
    assign accept    = rst_n && state == IDLE && ace_ready && !snoop_busy && |req_valid;
    assign req_ready = accept ? pick_gnt : '0;
    assign win_op    = ace_op_e'(req_op[2*pick_id +: 2]);

    // rr_ptr holds the highest-priority id, i.e. one past the last completed grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            to_cnt      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            read_req    <= 1'b0;
            invalid_req <= 1'b0;
            write_req   <= 1'b0;
            req_done    <= '0;
        end else begin
            read_req    <= 1'b0;
            invalid_req <= 1'b0;
            write_req   <= 1'b0;
            req_done    <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ISSUE;
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        case (win_op)
                            OP_WRITE:   write_req   <= 1'b1;
                            OP_INVALID: invalid_req <= 1'b1;
                            default:    read_req    <= 1'b1;
                        endcase
                    end
                end
                ISSUE: state <= HOLD;
                HOLD: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (ace_ready) begin
                        state    <= DONE;
                        req_done <= NUM_REQ'(1) << grant_id;
                    end else if (TIMEOUT_CYCLES != 0 && to_cnt == CW'(TIMEOUT_CYCLES)) begin
                        state       <= ERROR;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
                ERROR: state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_req_arbiter.sv
// Bench for ace_req_arbiter: vector table for arbitration order plus hand-written corner sequences.
module tb_ace_req_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [2*N-1:0] req_op;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_done;
    logic         read_req, invalid_req, write_req;
    logic         ace_ready, snoop_busy;
    logic [1:0]   grant_id;
    logic         busy, timeout_err;

    int checks   = 0;
    int failures = 0;
    int done_q[$];
    int op_q[$];

    typedef struct {
        logic [2:0] valid;
        logic [5:0] op;
        int         exp_id;
        int         exp_kind;   // 0 read, 1 invalid, 2 write
    } vec_t;
    vec_t vecs[12];

    ace_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .WRITE_PRIORITY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .req_done(req_done), .read_req(read_req),
        .invalid_req(invalid_req), .write_req(write_req), .ace_ready(ace_ready),
        .snoop_busy(snoop_busy), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pulses and completions are popped as the DUT produces them.
    always @(negedge clk) begin
        int e;
        int np;
        int kind;
        #2;
        if (req_done != 0) begin
            if (done_q.size() == 0) chk("unexpected_done", 32'(req_done), 0);
            else begin
                e = done_q.pop_front();
                chk("done_onehot", 32'(req_done), 1 << e);
                chk("done_grant_id", 32'(grant_id), e);
            end
        end
        np = int'(read_req) + int'(invalid_req) + int'(write_req);
        if (np > 1) chk("multi_pulse", np, 1);
        else if (np == 1) begin
            kind = write_req ? 2 : (invalid_req ? 1 : 0);
            if (op_q.size() == 0) chk("unexpected_pulse", kind, 99);
            else begin
                e = op_q.pop_front();
                chk("pulse_kind", kind, e);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic transact(input string name, input logic [2:0] v, input logic [5:0] o,
                            input int exp_id, input int exp_kind);
        int n = 0;
        @(negedge clk); req_valid = v; req_op = o; #1;
        while (req_ready == 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_ready"}, 32'(req_ready), 1 << exp_id);
        if (req_ready != 0) begin
            op_q.push_back(exp_kind);
            done_q.push_back(exp_id);
        end
        @(negedge clk); req_valid = '0; #1;
        wait_idle(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int bad;
        // op field is {op2, op1, op0}
        vecs[0]  = '{3'b111, 6'b000000, 0, 0};
        vecs[1]  = '{3'b111, 6'b000000, 1, 0};
        vecs[2]  = '{3'b111, 6'b000000, 2, 0};
        vecs[3]  = '{3'b111, 6'b000000, 0, 0};
        vecs[4]  = '{3'b011, 6'b001000, 1, 2};
        vecs[5]  = '{3'b011, 6'b000000, 0, 0};
        vecs[6]  = '{3'b101, 6'b000010, 0, 2};
        vecs[7]  = '{3'b100, 6'b110000, 2, 0};
        vecs[8]  = '{3'b010, 6'b000100, 1, 1};
        vecs[9]  = '{3'b110, 6'b011000, 1, 2};
        vecs[10] = '{3'b111, 6'b100101, 2, 2};
        vecs[11] = '{3'b011, 6'b000001, 0, 1};

        rst_n = 1'b0; req_valid = '0; req_op = '0; ace_ready = 1'b1; snoop_busy = 1'b0;
        @(negedge clk); req_valid = 3'b111; #1;
        chk("rst_ready_gated", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", 32'({req_ready, req_done, read_req, invalid_req, write_req,
                                grant_id, busy, timeout_err}), 0);
        @(negedge clk); rst_n = 1'b1; req_valid = '0; #1;

        for (int i = 0; i < 12; i++)
            transact($sformatf("vec%0d", i), vecs[i].valid, vecs[i].op, vecs[i].exp_id, vecs[i].exp_kind);

        // Write with controller busy T+2..T+5: done lands at T+7.
        @(negedge clk); req_valid = 3'b001; req_op = 6'b000010; ace_ready = 1'b1; #1;
        chk("a_ready_T", 32'(req_ready), 3'b001);
        op_q.push_back(2); done_q.push_back(0);
        @(negedge clk); req_valid = '0; #1;
        chk("a_write_T1", 32'(write_req), 1);
        @(negedge clk); ace_ready = 1'b0; #1;
        chk("a_busy_T2", 32'(busy), 1);
        bad = 0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk); if (k == 6) ace_ready = 1'b1; #1;
            if (req_done != 0) bad++;
        end
        chk("a_no_early_done", bad, 0);
        @(negedge clk); #1;
        chk("a_done_T7", 32'(req_done), 3'b001);
        chk("a_grant_id", 32'(grant_id), 0);
        wait_idle("a");

        // Snoop holds off accepts, including a request rising in the same cycle.
        @(negedge clk); snoop_busy = 1'b1; req_valid = 3'b100; req_op = '0; #1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (req_ready != 0) bad++;
        end
        chk("b_no_ready_snoop", bad, 0);
        @(negedge clk); snoop_busy = 1'b0; #1;
        chk("b_ready_after_snoop", 32'(req_ready), 3'b100);
        op_q.push_back(0); done_q.push_back(2);
        @(negedge clk); req_valid = '0; #1;
        wait_idle("b");

        // ace_ready low in IDLE stalls; a request withdrawn before accept vanishes.
        @(negedge clk); ace_ready = 1'b0; req_valid = 3'b010; #1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (req_ready != 0 || busy || timeout_err) bad++;
        end
        chk("c_stall_no_accept", bad, 0);
        @(negedge clk); req_valid = '0; ace_ready = 1'b1; #1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (req_ready != 0 || req_done != 0 || busy || read_req || write_req || invalid_req) bad++;
        end
        chk("c_dropped_request", bad, 0);

        // Reset during WAIT drops the transaction.
        @(negedge clk); req_valid = 3'b001; req_op = '0; #1;
        chk("d_ready", 32'(req_ready), 3'b001);
        op_q.push_back(0);
        @(negedge clk); req_valid = '0;
        @(negedge clk); ace_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        chk("d_reset_outputs", 32'({req_ready, req_done, read_req, invalid_req, write_req,
                                    grant_id, busy, timeout_err}), 0);
        rst_n = 1'b1; ace_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (req_done != 0 || busy) bad++;
        end
        chk("d_no_done_after_reset", bad, 0);

        // Op 11 issues a read; reset during ISSUE clears the pulse at the next edge.
        @(negedge clk); req_valid = 3'b100; req_op = 6'b110000; #1;
        chk("f_ready", 32'(req_ready), 3'b100);
        op_q.push_back(0);
        @(negedge clk); req_valid = '0; rst_n = 1'b0; #1;
        chk("f_rsvd_read_pulse", 32'(read_req), 1);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("f_pulse_cleared", 32'({read_req, busy, grant_id}), 0);

        // Timeout: ERROR exactly TO+1 edges after entering WAIT.
        @(negedge clk); req_valid = 3'b010; req_op = 6'b001000; ace_ready = 1'b1; #1;
        chk("e_ready", 32'(req_ready), 3'b010);
        op_q.push_back(2);
        @(negedge clk); req_valid = '0;
        @(negedge clk); ace_ready = 1'b0;
        bad = 0;
        for (int k = 3; k <= 3 + TO; k++) begin
            @(negedge clk); #1;
            if (timeout_err) bad++;
        end
        chk("e_no_early_timeout", bad, 0);
        @(negedge clk); #1;
        chk("e_timeout_edge", 32'(timeout_err), 1);
        chk("e_busy_error", 32'(busy), 1);
        @(negedge clk); ace_ready = 1'b1; req_valid = 3'b111; req_op = '0; #1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (req_ready != 0 || req_done != 0 || read_req || write_req || invalid_req ||
                !timeout_err || !busy) bad++;
        end
        chk("e_error_ignores_reqs", bad, 0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        chk("e_reset_clears", 32'({req_ready, req_done, read_req, invalid_req, write_req,
                                   grant_id, busy, timeout_err}), 0);
        rst_n = 1'b1; req_valid = '0;
        transact("post_err", 3'b001, 6'b000000, 0, 0);

        repeat (3) @(negedge clk);
        #3;
        chk("done_q_empty", done_q.size(), 0);
        chk("op_q_empty", op_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
